// File: rtl/i2c_master_reader_if.sv
// Bundles the request/result handshake and the open-drain SCL/SDA pair of the
// I2C read master, with one modport for the master and one for its environment.
interface i2c_master_reader_if #(
  parameter int CNT_W = 8
);
  // Handshake: start_req is a level request. It is accepted on a clock where
  // the master is idle (busy=0) and byte_count!=0, and ignored at all other
  // times. busy is high from the cycle after acceptance until the cycle after
  // the done pulse. rx_valid and done are single-cycle strobes with no
  // back-pressure, so the environment must take rx_data on the rx_valid cycle.
  logic             start_req;
  logic [6:0]       slave_addr;
  logic [CNT_W-1:0] byte_count;
  logic             sda_in;
  logic             scl_out;
  logic             sda_out;
  logic             busy;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             addr_nack;
  logic             done;

  modport master (
    input  start_req, slave_addr, byte_count, sda_in,
    output scl_out, sda_out, busy, rx_data, rx_valid, addr_nack, done
  );

  modport slave (
    output start_req, slave_addr, byte_count, sda_in,
    input  scl_out, sda_out, busy, rx_data, rx_valid, addr_nack, done
  );
endinterface

// File: rtl/i2c_master_reader.sv
// I2C master that reads byte_count bytes from a read-only slave: START, address+R,
// address ACK check, N bytes (ACK all but the last, NACK the last), then STOP.
module i2c_master_reader #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  i2c_master_reader_if.master bus,
  output logic [2:0]          state_o
);
  localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    ADDR     = 3'd2,
    ADDR_ACK = 3'd3,
    RX_BYTE  = 3'd4,
    SEND_ACK = 3'd5,
    STOP     = 3'd6,
    DONE     = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [1:0]       quarter_q, quarter_d;
  logic [2:0]       bit_q, bit_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [6:0]       addr_q, addr_d;
  logic [6:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             addr_nack_q, addr_nack_d;
  logic             ack_q, ack_d;

  logic       phase_end, sample_en, bit_end;
  logic [7:0] addr_byte;
  logic       scl, sda;

  assign phase_end = (phase_q == PH_W'(CLK_DIV - 1));
  assign sample_en = phase_end && (quarter_q == 2'd2);
  assign bit_end   = phase_end && (quarter_q == 2'd3);
  assign addr_byte = {addr_q, 1'b1};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      quarter_q   <= '0;
      bit_q       <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      addr_nack_q <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      quarter_q   <= quarter_d;
      bit_q       <= bit_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      addr_nack_q <= addr_nack_d;
      ack_q       <= ack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    quarter_d   = quarter_q;
    bit_d       = bit_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    addr_nack_d = addr_nack_q;
    ack_d       = ack_q;

    // The bit-timing counters only run while a bus state is active.
    if (state_q == IDLE || state_q == DONE) begin
      phase_d   = '0;
      quarter_d = '0;
    end else if (phase_end) begin
      phase_d   = '0;
      quarter_d = quarter_q + 2'd1;
    end else begin
      phase_d = phase_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start_req && (bus.byte_count != '0)) begin
          addr_d      = bus.slave_addr;
          remaining_d = bus.byte_count;
          addr_nack_d = 1'b0;
          bit_d       = '0;
          state_d     = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ADDR_ACK;
        end
      end
      ADDR_ACK: begin
        if (sample_en) begin
          ack_d = bus.sda_in;
          if (bus.sda_in) addr_nack_d = 1'b1;
        end
        if (bit_end) begin
          bit_d   = '0;
          state_d = ack_q ? STOP : RX_BYTE;
        end
      end
      RX_BYTE: begin
        if (sample_en) begin
          shift_d = {shift_q[5:0], bus.sda_in};
          if (bit_q == 3'd7) begin
            rx_data_d  = {shift_q, bus.sda_in};
            rx_valid_d = 1'b1;
          end
        end
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = SEND_ACK;
        end
      end
      SEND_ACK: begin
        // Deciding on remaining==1 keeps the counter from ever wrapping below 1.
        if (bit_end) begin
          bit_d = '0;
          if (remaining_q > CNT_W'(1)) begin
            remaining_d = remaining_q - CNT_W'(1);
            state_d     = RX_BYTE;
          end else begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_end) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus drive is decoded from registered state, so an asynchronous reset
  // releases both lines in the same cycle.
  always_comb begin
    scl = 1'b1;
    sda = 1'b1;
    unique case (state_q)
      START:    sda = ~quarter_q[1];
      ADDR: begin
        scl = quarter_q[1];
        sda = addr_byte[3'd7 - bit_q];
      end
      ADDR_ACK: scl = quarter_q[1];
      RX_BYTE:  scl = quarter_q[1];
      SEND_ACK: begin
        scl = quarter_q[1];
        sda = ~(remaining_q > CNT_W'(1));
      end
      STOP: begin
        scl = quarter_q[1];
        sda = (quarter_q == 2'd3);
      end
      default: begin
        scl = 1'b1;
        sda = 1'b1;
      end
    endcase
  end

  assign bus.scl_out   = scl;
  assign bus.sda_out   = sda;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.addr_nack = addr_nack_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_i2c_master_reader.sv
// Directed bench for i2c_master_reader: a bus-level read-only slave model on the
// open-drain pair, a received-byte scoreboard, and timing/protocol checks.
module tb_i2c_master_reader;
  localparam int CLK_DIV = 2;
  localparam int BIT_CLK = 4 * CLK_DIV;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RX   = 3'd4;

  logic       clk;
  logic       n_rst;
  logic [2:0] state_o;
  logic       sda_line;

  i2c_master_reader_if #(.CNT_W(8)) bus ();

  i2c_master_reader #(.CLK_DIV(CLK_DIV), .CNT_W(8)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .bus     (bus.master),
    .state_o (state_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // slave model: open-drain bus, captures address and master ACK bits
  logic       slv_drv;
  logic       prev_scl, prev_sda;
  logic       slv_active;
  int         rises;
  logic [7:0] cap_addr;
  logic [7:0] slv_data [8];
  int         slv_n;
  logic       slv_ack_en;
  logic       ack_log [$];
  int         stop_cnt;

  assign sda_line   = bus.sda_out & slv_drv;
  assign bus.sda_in = sda_line;

  always @(negedge clk or negedge n_rst) begin
    int r;
    if (!n_rst) begin
      slv_drv    <= 1'b1;
      slv_active <= 1'b0;
      rises      <= 0;
      prev_scl   <= 1'b1;
      prev_sda   <= 1'b1;
    end else begin
      prev_scl <= bus.scl_out;
      prev_sda <= sda_line;
      if (prev_scl && bus.scl_out && prev_sda && !sda_line) begin
        slv_active <= 1'b1;
        rises      <= 0;
      end else if (prev_scl && bus.scl_out && !prev_sda && sda_line && slv_active) begin
        slv_active <= 1'b0;
        slv_drv    <= 1'b1;
        stop_cnt   <= stop_cnt + 1;
      end else if (!prev_scl && bus.scl_out && slv_active) begin
        r = rises + 1;
        rises <= r;
        if (r <= 8) cap_addr <= {cap_addr[6:0], sda_line};
        if (r > 9 && ((r - 9) % 9) == 0) ack_log.push_back(sda_line);
      end else if (prev_scl && !bus.scl_out && slv_active) begin
        r = rises;
        if (r == 8)
          slv_drv <= ~slv_ack_en;
        else if (r >= 9 && slv_ack_en && ((r - 9) / 9) < slv_n && ((r - 9) % 9) < 8)
          slv_drv <= slv_data[(r - 9) / 9][7 - ((r - 9) % 9)];
        else
          slv_drv <= 1'b1;
      end
    end
  end

  // scoreboard and monitors
  logic [7:0] exp_q [$];
  int   rx_cnt;
  int   done_cnt;
  int   rise_cyc;
  int   exp_lat;
  logic prev_busy;

  always @(negedge clk) begin
    logic [7:0] e;
    if (n_rst && bus.rx_valid) begin
      rx_cnt <= rx_cnt + 1;
      if (exp_q.size() == 0) begin
        check("rx_unexpected", 32'(bus.rx_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", 32'(bus.rx_data), 32'(e));
      end
    end
  end

  always @(negedge clk) begin
    prev_busy <= bus.busy;
    if (bus.busy && !prev_busy) rise_cyc <= cyc;
    if (n_rst && bus.done) begin
      done_cnt <= done_cnt + 1;
      check("done_latency", 32'(cyc - rise_cyc), 32'(exp_lat));
    end
  end

  // driver tasks
  task automatic launch(input logic [6:0] addr, input int n, input logic ack_en);
    slv_n      = n;
    slv_ack_en = ack_en;
    rx_cnt     = 0;
    ack_log.delete();
    if (ack_en) begin
      for (int i = 0; i < n; i++) exp_q.push_back(slv_data[i]);
      exp_lat = (11 + 9 * n) * BIT_CLK;
    end else begin
      exp_lat = 11 * BIT_CLK;
    end
    @(negedge clk);
    bus.slave_addr = addr;
    bus.byte_count = 8'(n);
    bus.start_req  = 1'b1;
    @(negedge clk);
    bus.start_req  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int start_cnt;
    int i;
    start_cnt = done_cnt;
    for (i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (done_cnt != start_cnt) break;
    end
    check(tag, 32'(done_cnt != start_cnt), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [31:0] pack_acks();
    logic [31:0] v;
    v = '0;
    foreach (ack_log[i]) v = {v[30:0], ack_log[i]};
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    int saved_done;
    int saved_stop;
    int i;

    n_rst          = 1'b0;
    bus.start_req  = 1'b0;
    bus.slave_addr = '0;
    bus.byte_count = '0;
    stop_cnt       = 0;
    done_cnt       = 0;
    rx_cnt         = 0;
    rise_cyc       = 0;
    exp_lat        = 0;
    slv_n          = 0;
    slv_ack_en     = 1'b1;
    cap_addr       = '0;
    foreach (slv_data[k]) slv_data[k] = '0;
    repeat (4) @(negedge clk);
    n_rst = 1'b1;

    // idle after reset: bus released, no pulses
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.scl_out !== 1'b1 || bus.sda_out !== 1'b1 || bus.busy !== 1'b0 ||
          bus.rx_valid !== 1'b0 || bus.done !== 1'b0 || bus.addr_nack !== 1'b0) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);
    check("reset_rx_data", 32'(bus.rx_data), 32'h0);
    check("reset_state", 32'(state_o), 32'(ST_IDLE));

    // one byte from 7'h3A
    slv_data[0] = 8'hA5;
    saved_stop = stop_cnt;
    launch(7'h3A, 1, 1'b1);
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    wait_done("t1_done_seen", 400);
    check("t1_addr_bits", 32'(cap_addr), 32'h75);
    check("t1_rx_count", 32'(rx_cnt), 32'd1);
    check("t1_master_acks", pack_acks(), 32'b1);
    check("t1_ack_count", 32'(ack_log.size()), 32'd1);
    check("t1_stop", 32'(stop_cnt - saved_stop), 32'd1);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t1_busy_low", 32'(bus.busy), 32'd0);

    // three bytes: ACK, ACK, NACK
    slv_data[0] = 8'h01;
    slv_data[1] = 8'hFF;
    slv_data[2] = 8'h80;
    launch(7'h3A, 3, 1'b1);
    wait_done("t2_done_seen", 800);
    check("t2_rx_count", 32'(rx_cnt), 32'd3);
    check("t2_master_acks", pack_acks(), 32'b001);
    check("t2_rx_last", 32'(bus.rx_data), 32'h80);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // address NACK
    saved_stop = stop_cnt;
    launch(7'h15, 1, 1'b0);
    wait_done("t3_done_seen", 400);
    check("t3_addr_nack", 32'(bus.addr_nack), 32'd1);
    check("t3_rx_count", 32'(rx_cnt), 32'd0);
    check("t3_stop", 32'(stop_cnt - saved_stop), 32'd1);
    repeat (10) @(negedge clk);
    check("t3_nack_sticky", 32'(bus.addr_nack), 32'd1);

    // fresh accept clears addr_nack; a repeated start_req mid-transaction is ignored
    slv_data[0] = 8'h5C;
    slv_data[1] = 8'hC3;
    launch(7'h51, 2, 1'b1);
    check("t4_nack_cleared", 32'(bus.addr_nack), 32'd0);
    repeat (30) @(negedge clk);
    bus.slave_addr = 7'h7F;
    bus.byte_count = 8'd5;
    bus.start_req  = 1'b1;
    repeat (10) @(negedge clk);
    bus.start_req  = 1'b0;
    wait_done("t4_done_seen", 600);
    check("t4_addr_bits", 32'(cap_addr), 32'hA3);
    check("t4_rx_count", 32'(rx_cnt), 32'd2);
    check("t4_master_acks", pack_acks(), 32'b01);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // byte_count = 0 in IDLE is ignored
    saved_done = done_cnt;
    bus.byte_count = 8'd0;
    bus.start_req  = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.scl_out !== 1'b1 || bus.sda_out !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    bus.start_req = 1'b0;
    check("t5_zero_count_quiet", 32'(bad), 32'd0);
    check("t5_no_done", 32'(done_cnt - saved_done), 32'd0);

    // reset during the 4th bit of the first data byte
    slv_data[0] = 8'h0F;
    slv_data[1] = 8'hF0;
    launch(7'h22, 2, 1'b1);
    for (i = 0; i < 200; i++) begin
      if (state_o == ST_RX) break;
      @(negedge clk);
    end
    check("t6_reached_rx", 32'(state_o), 32'(ST_RX));
    repeat (3 * BIT_CLK + 3) @(negedge clk);
    saved_done = done_cnt;
    n_rst = 1'b0;
    #1;
    check("t6_scl_released", 32'(bus.scl_out), 32'd1);
    check("t6_sda_released", 32'(bus.sda_out), 32'd1);
    check("t6_busy_low", 32'(bus.busy), 32'd0);
    repeat (5) @(negedge clk);
    n_rst = 1'b1;
    exp_q.delete();
    repeat (40) @(negedge clk);
    check("t6_no_done", 32'(done_cnt - saved_done), 32'd0);
    check("t6_idle_state", 32'(state_o), 32'(ST_IDLE));

    // a fresh transaction after the abort
    slv_data[0] = 8'h3C;
    launch(7'h2C, 1, 1'b1);
    wait_done("t7_done_seen", 400);
    check("t7_addr_bits", 32'(cap_addr), 32'h59);
    check("t7_rx_count", 32'(rx_cnt), 32'd1);
    check("t7_rx_data", 32'(bus.rx_data), 32'h3C);
    check("t7_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
